// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
//
// parity_e    : line parity mode, numerically equal to the PARITY_MODE parameter
// rx_state_e  : receiver FSM states
// parity_calc : the parity bit a correct transmitter sends for a data word
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  // Widest supported data word; narrower words are zero-extended, which
  // leaves their XOR reduction unchanged.
  localparam int MAX_DATA_BITS = 9;

  function automatic logic parity_calc(input logic [MAX_DATA_BITS-1:0] data,
                                       input parity_e                  mode);
    logic p;
    case (mode)
      PAR_EVEN: p = ^data;
      PAR_ODD:  p = ~(^data);
      default:  p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_rx_baud_counter.sv
// Bit-period timer: one-clock sample_tick at the half or full bit period.
// Latency: sample_tick is combinational from the counter; counter restarts on the tick edge.
// Backpressure: none; free-running while clear is low.
//
// clk, reset  : system clock, synchronous active-high reset
// clear       : hold the counter at zero (receiver idle)
// half        : 1 = time half a bit (start-bit centring), 0 = a full bit
// sample_tick : high for the one clock in which the selected period ends
module uart_rx_baud_counter #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic half,
  output logic sample_tick
);

  localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic [CNT_W-1:0] cnt;
  logic             hit;

  assign hit         = half ? (cnt == HALF_LAST) : (cnt == FULL_LAST);
  assign sample_tick = hit & ~clear;

  // Restarting on every tick keeps each subsequent sample exactly one
  // bit period after the previous one, so the count never passes FULL_LAST.
  always_ff @(posedge clk) begin
    if (reset || clear || hit) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: sync, start validation, data/parity/stop sampling, word output.
// Latency: rx_valid rises 1 clk after the mid-bit sample of the final stop bit.
// Backpressure: valid/ready; a frame completing while a word is still held is dropped with an overrun pulse.
//
// clk, reset  : system clock, synchronous active-high reset
// rx          : asynchronous serial input, idle high
// rx_data     : received word, stable while rx_valid is high
// rx_valid    : word available, held until rx_ready
// rx_ready    : consumer accept
// parity_err  : parity check failed for rx_data (always 0 without parity)
// frame_err   : at least one stop bit of rx_data was sampled low
// overrun     : one-clock pulse when a completed frame was discarded
// busy        : receiver is inside a frame
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam logic [1:0] PMODE_BITS = PARITY_MODE[1:0];
  localparam parity_e    PMODE      = parity_e'(PMODE_BITS);
  localparam logic [3:0] DATA_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST  = 4'(STOP_BITS - 1);

  rx_state_e                 state;
  logic                      rx_meta;
  logic                      rx_s;
  logic [3:0]                bit_cnt;
  logic [DATA_BITS-1:0]      shift_reg;
  logic [MAX_DATA_BITS-1:0]  data_ext;
  logic                      parity_err_n;
  logic                      frame_err_n;
  logic                      tick;
  logic                      stop_bad;
  logic                      can_load;

  // Two-flop synchroniser, preset to the idle line level.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  uart_rx_baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk         (clk),
    .reset       (reset),
    .clear       (state == IDLE),
    .half        (state == START),
    .sample_tick (tick)
  );

  assign data_ext = MAX_DATA_BITS'(shift_reg);
  assign stop_bad = ~rx_s;
  // The held word may be replaced when nothing is held or it is being
  // accepted in this same clock.
  assign can_load = ~rx_valid | rx_ready;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      parity_err_n <= 1'b0;
      frame_err_n  <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      overrun <= 1'b0;
      // Accept first; a completing frame below overrides this to keep valid high.
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state        <= START;
            bit_cnt      <= '0;
            parity_err_n <= 1'b0;
            frame_err_n  <= 1'b0;
          end
        end

        START: begin
          if (tick) begin
            // A line back high at mid-start is a glitch, not a frame.
            state   <= rx_s ? IDLE : DATA;
            bit_cnt <= '0;
          end
        end

        DATA: begin
          if (tick) begin
            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= (PMODE != PAR_NONE) ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        PARITY: begin
          if (tick) begin
            parity_err_n <= rx_s ^ parity_calc(data_ext, PMODE);
            bit_cnt      <= '0;
            state        <= STOP;
          end
        end

        STOP: begin
          if (tick) begin
            frame_err_n <= frame_err_n | stop_bad;
            if (bit_cnt == STOP_LAST) begin
              // No wait for the line to rise: a low line restarts at once.
              state   <= IDLE;
              bit_cnt <= '0;
              if (can_load) begin
                rx_data    <= shift_reg;
                parity_err <= parity_err_n;
                frame_err  <= frame_err_n | stop_bad;
                rx_valid   <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: directed cases plus random frames against a frame-level model.
// Latency: n/a.
// Backpressure: exercises held words, overrun and simultaneous accept.
module tb_uart_rx_param;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, frame_err, overrun, busy;

  logic       rx2 = 1'b1;
  logic       rx_ready2 = 1'b1;
  logic [6:0] rx_data2;
  logic       rx_valid2, parity_err2, frame_err2, overrun2, busy2;

  always #5 clk = ~clk;

  uart_rx_param #(
    .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .parity_err(parity_err), .frame_err(frame_err),
    .overrun(overrun), .busy(busy)
  );

  uart_rx_param #(
    .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2), .CLKS_PER_BIT(CPB)
  ) dut2 (
    .clk(clk), .reset(reset), .rx(rx2), .rx_data(rx_data2), .rx_valid(rx_valid2),
    .rx_ready(rx_ready2), .parity_err(parity_err2), .frame_err(frame_err2),
    .overrun(overrun2), .busy(busy2)
  );

  typedef struct packed {
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } word_t;

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    rise_cyc = 0;
  int    vld_cnt = 0;
  int    ovr_cnt = 0;
  logic  prev_vld = 1'b0;
  word_t got_q[$];
  word_t got2_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every accepted word from both receivers.
  always @(negedge clk) begin
    word_t w;
    if (rx_valid && rx_ready) begin
      w.d  = {1'b0, rx_data};
      w.pe = parity_err;
      w.fe = frame_err;
      got_q.push_back(w);
    end
    if (rx_valid2 && rx_ready2) begin
      w.d  = {2'b00, rx_data2};
      w.pe = parity_err2;
      w.fe = frame_err2;
      got2_q.push_back(w);
    end
    if (rx_valid && !prev_vld) rise_cyc = cyc;
    if (rx_valid) vld_cnt++;
    if (overrun) ovr_cnt++;
    prev_vld = rx_valid;
  end

  // Parity bit a correct transmitter would send.
  function automatic logic good_par(input logic [8:0] data, input int dbits, input int pmode);
    logic [8:0] m;
    int         ones;
    m    = data & ((9'h1 << dbits) - 9'h1);
    ones = $countones(m);
    return (pmode == 2) ? ~ones[0] : ones[0];
  endfunction

  function automatic word_t model(input logic [8:0] data, input int dbits, input int pmode,
                                  input logic par_bit, input int nstops, input logic [1:0] stop_bits);
    word_t w;
    w.d  = data & ((9'h1 << dbits) - 9'h1);
    w.pe = (pmode != 0) && (par_bit != good_par(data, dbits, pmode));
    w.fe = 1'b0;
    for (int i = 0; i < nstops; i++) if (!stop_bits[i]) w.fe = 1'b1;
    return w;
  endfunction

  // Drives n bits (bit 0 first), each CPB clocks; starts and ends at posedge+1.
  task automatic send_bits(input logic sel, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel) rx2 = bits[i];
      else     rx  = bits[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic sel, input logic [8:0] data, input int dbits, input int pmode,
                            input logic par_bit, input int nstops, input logic [1:0] stop_bits,
                            input int gap);
    logic [15:0] b;
    int          n;
    b    = '0;
    n    = 1;               // bit 0 is the start bit (0)
    for (int i = 0; i < dbits; i++) begin b[n] = data[i]; n++; end
    if (pmode != 0) begin b[n] = par_bit; n++; end
    for (int i = 0; i < nstops; i++) begin b[n] = stop_bits[i]; n++; end
    send_bits(sel, b, n);
    if (sel) rx2 = 1'b1;
    else     rx  = 1'b1;
    for (int i = 0; i < gap; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_words(input logic sel, input string tag);
    int budget;
    budget = 4 * CPB;
    while (((sel ? got2_q.size() : got_q.size()) < 1) && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    if (budget == 0) check_eq({tag, "_timeout"}, 32'(sel ? got2_q.size() : got_q.size()), 32'd1);
  endtask

  task automatic run_frame(input logic sel, input logic [8:0] data, input int dbits, input int pmode,
                           input logic par_bit, input int nstops, input logic [1:0] stop_bits,
                           input int gap, input string tag);
    word_t e, g;
    e = model(data, dbits, pmode, par_bit, nstops, stop_bits);
    send_frame(sel, data, dbits, pmode, par_bit, nstops, stop_bits, gap);
    wait_words(sel, tag);
    if ((sel ? got2_q.size() : got_q.size()) > 0) begin
      g = sel ? got2_q.pop_front() : got_q.pop_front();
      check_eq({tag, "_data"},   32'(g.d),  32'(e.d));
      check_eq({tag, "_parity"}, 32'(g.pe), 32'(e.pe));
      check_eq({tag, "_frame"},  32'(g.fe), 32'(e.fe));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int    start;
    int    v0, o0;
    logic [8:0] d;
    logic  p;
    logic [1:0] s;
    word_t g;

    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid",  32'(rx_valid),   32'd0);
    check_eq("rst_data",   32'(rx_data),    32'd0);
    check_eq("rst_perr",   32'(parity_err), 32'd0);
    check_eq("rst_ferr",   32'(frame_err),  32'd0);
    check_eq("rst_ovr",    32'(overrun),    32'd0);
    check_eq("rst_busy",   32'(busy),       32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Clean 0xA5; rx_valid rises 2 sync clocks + 1 detect clock + half a bit
    // + 10 full bits (to the mid-stop sample) after the start edge is driven.
    start = cyc;
    v0    = vld_cnt;
    run_frame(1'b0, 9'h0A5, 8, 1, 1'b0, 1, 2'b01, 8, "a5");
    check_eq("a5_latency", 32'(rise_cyc - start), 32'(3 + CPB / 2 + 10 * CPB));
    check_eq("a5_valid_clks", 32'(vld_cnt - v0), 32'd1);

    // Wrong parity bit
    run_frame(1'b0, 9'h03C, 8, 1, 1'b1, 1, 2'b01, 8, "par_err");

    // Stop bit low, next start immediately follows on a still-low line
    run_frame(1'b0, 9'h0FF, 8, 1, 1'b0, 1, 2'b00, 0, "stop_err");
    run_frame(1'b0, 9'h05A, 8, 1, 1'b0, 1, 2'b01, 8, "back2back");

    // 5-clock low glitch in idle
    v0 = vld_cnt;
    rx = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rx = 1'b1;
    check_eq("glitch_busy_hi", 32'(busy), 32'd1);
    repeat (12) @(posedge clk);
    #1;
    check_eq("glitch_busy_lo", 32'(busy), 32'd0);
    check_eq("glitch_no_valid", 32'(vld_cnt - v0), 32'd0);

    // Overrun: second frame dropped while the first is held
    rx_ready = 1'b0;
    o0 = ovr_cnt;
    send_frame(1'b0, 9'h011, 8, 1, good_par(9'h011, 8, 1), 1, 2'b01, 8);
    check_eq("ovr_first_valid", 32'(rx_valid), 32'd1);
    check_eq("ovr_first_data",  32'(rx_data),  32'h11);
    send_frame(1'b0, 9'h022, 8, 1, good_par(9'h022, 8, 1), 1, 2'b01, 8);
    check_eq("ovr_held_data",  32'(rx_data),       32'h11);
    check_eq("ovr_held_valid", 32'(rx_valid),      32'd1);
    check_eq("ovr_pulses",     32'(ovr_cnt - o0),  32'd1);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("ovr_accept_cnt", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) begin
      g = got_q.pop_front();
      check_eq("ovr_accept_data", 32'(g.d), 32'h11);
    end
    check_eq("ovr_valid_clr", 32'(rx_valid), 32'd0);

    // 7 data bits, odd parity, two stops with the second low
    run_frame(1'b1, 9'h055, 7, 2, 1'b1, 2, 2'b01, 8, "d7_odd");

    // Random frames on both configurations
    for (int i = 0; i < 20; i++) begin
      d = 9'($urandom_range(0, 255));
      p = good_par(d, 8, 1) ^ ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 4) == 0) ? 2'b00 : 2'b01;
      run_frame(1'b0, d, 8, 1, p, 1, s, $urandom_range(8, 40), "rnd8");
    end
    for (int i = 0; i < 8; i++) begin
      d = 9'($urandom_range(0, 127));
      p = good_par(d, 7, 2) ^ ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      run_frame(1'b1, d, 7, 2, p, 2, s, $urandom_range(8, 40), "rnd7");
    end

    // Reset in the middle of the data bits
    v0 = vld_cnt;
    send_bits(1'b0, 16'b0000_0000_0000_1010, 4);
    reset = 1'b1;
    rx    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("midrst_valid", 32'(rx_valid), 32'd0);
    check_eq("midrst_data",  32'(rx_data),  32'd0);
    check_eq("midrst_busy",  32'(busy),     32'd0);
    reset = 1'b0;
    repeat (3 * CPB) @(posedge clk);
    #1;
    check_eq("midrst_idle_busy", 32'(busy), 32'd0);
    check_eq("midrst_no_word",   32'(vld_cnt - v0), 32'd0);
    run_frame(1'b0, 9'h081, 8, 1, good_par(9'h081, 8, 1), 1, 2'b01, 8, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
